// File: rtl/vram_rect_fill_if.sv
// Command and frame-buffer write-port bundle for vram_rect_fill.
// The slave side is the fill engine and the master side is whoever issues
// rectangle commands and owns the frame buffer.
interface vram_rect_fill_if;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [5:0]         cmd_x;
    logic [5:0]         cmd_y;
    logic [6:0]         cmd_w;
    logic [6:0]         cmd_h;
    logic [7:0]         cmd_color;
    logic               busy;
    logic               done;
    logic               vsync;
    logic signed [31:0] data_address;
    logic signed [7:0]  data_din;
    logic               data_we;

    modport slave (
        input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, vsync,
        output cmd_ready, busy, done, data_address, data_din, data_we
    );

    modport master (
        output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, vsync,
        input  cmd_ready, busy, done, data_address, data_din, data_we
    );
endinterface

// File: rtl/vram_rect_fill.sv
// Rectangle-fill engine for the 64x64 8bpp VGA frame buffer.
// Accepts one command at a time, clips it to the frame and writes one pixel
// per clock in raster order through registered write-port outputs.
// Optional feature: define VRAM_RECT_FILL_VSYNC_WAIT_EN to hold each
// non-empty fill until the next falling edge of the synchronized vsync.
module vram_rect_fill #(
    parameter int C_FB_W = 64,
    parameter int C_FB_H = 64
) (
    input  logic              clk,
    input  logic              reset,
    vram_rect_fill_if.slave   bus
);

    localparam logic [1:0] S_IDLE    = 2'd0;
`ifdef VRAM_RECT_FILL_VSYNC_WAIT_EN
    localparam logic [1:0] S_WAIT_VS = 2'd1;
`endif
    localparam logic [1:0] S_FILL    = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam logic [7:0] FB_W8 = 8'(C_FB_W);
    localparam logic [7:0] FB_H8 = 8'(C_FB_H);

    logic [1:0]  state_q, state_d;
    logic [5:0]  col_q, col_d;
    logic [5:0]  row_q, row_d;
    logic [5:0]  startCol_q, startCol_d;
    logic [5:0]  lastCol_q, lastCol_d;
    logic [5:0]  lastRow_q, lastRow_d;
    logic [7:0]  color_q, color_d;
    logic        we_q, we_d;
    logic [11:0] addr_q, addr_d;
    logic [7:0]  din_q, din_d;
    logic        done_q, done_d;
    logic [1:0]  vsSync_q;

    logic [7:0]  xExt, yExt, roomX, roomY, effW, effH;

`ifdef VRAM_RECT_FILL_VSYNC_WAIT_EN
    logic        vsPrev_q;
    logic        vsFall;
    assign vsFall = vsPrev_q & ~vsSync_q[1];
`else
    logic        unusedVsync;
    assign unusedVsync = vsSync_q[1];
`endif

    // Clip the incoming command against the frame edges in 8-bit unsigned math.
    always_comb begin
        xExt  = {2'b00, bus.cmd_x};
        yExt  = {2'b00, bus.cmd_y};
        roomX = (xExt >= FB_W8) ? 8'd0 : FB_W8 - xExt;
        roomY = (yExt >= FB_H8) ? 8'd0 : FB_H8 - yExt;
        effW  = ({1'b0, bus.cmd_w} < roomX) ? {1'b0, bus.cmd_w} : roomX;
        effH  = ({1'b0, bus.cmd_h} < roomY) ? {1'b0, bus.cmd_h} : roomY;
    end

    // Next-state logic: accept, optional vsync wait, raster walk and done pulse.
    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        startCol_d = startCol_q;
        lastCol_d  = lastCol_q;
        lastRow_d  = lastRow_q;
        color_d    = color_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        din_d      = din_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    startCol_d = bus.cmd_x;
                    col_d      = bus.cmd_x;
                    row_d      = bus.cmd_y;
                    lastCol_d  = 6'(xExt + effW - 8'd1);
                    lastRow_d  = 6'(yExt + effH - 8'd1);
                    color_d    = bus.cmd_color;
                    if (effW == 8'd0 || effH == 8'd0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
`ifdef VRAM_RECT_FILL_VSYNC_WAIT_EN
                        state_d = S_WAIT_VS;
`else
                        state_d = S_FILL;
                        we_d    = 1'b1;
`endif
                    end
                end
            end
`ifdef VRAM_RECT_FILL_VSYNC_WAIT_EN
            S_WAIT_VS: begin
                if (vsFall) begin
                    state_d = S_FILL;
                    we_d    = 1'b1;
                end
            end
`endif
            S_FILL: begin
                if (col_q == lastCol_q) begin
                    if (row_q == lastRow_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        col_d = startCol_q;
                        row_d = row_q + 6'd1;
                        we_d  = 1'b1;
                    end
                end else begin
                    col_d = col_q + 6'd1;
                    we_d  = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (we_d) begin
            addr_d = {row_d, col_d};
            din_d  = color_d;
        end
    end

    // State and write-port registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            col_q      <= 6'd0;
            row_q      <= 6'd0;
            startCol_q <= 6'd0;
            lastCol_q  <= 6'd0;
            lastRow_q  <= 6'd0;
            color_q    <= 8'd0;
            we_q       <= 1'b0;
            addr_q     <= 12'd0;
            din_q      <= 8'd0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            startCol_q <= startCol_d;
            lastCol_q  <= lastCol_d;
            lastRow_q  <= lastRow_d;
            color_q    <= color_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            done_q     <= done_d;
        end
    end

    // Two-flop synchronizer bringing vsync into the clk domain (idle level high).
    always_ff @(posedge clk) begin
        if (reset) begin
            vsSync_q <= 2'b11;
        end else begin
            vsSync_q <= {vsSync_q[0], bus.vsync};
        end
    end

`ifdef VRAM_RECT_FILL_VSYNC_WAIT_EN
    // Previous synchronized vsync level, used to spot the start of vertical blank.
    always_ff @(posedge clk) begin
        if (reset) begin
            vsPrev_q <= 1'b1;
        end else begin
            vsPrev_q <= vsSync_q[1];
        end
    end
`endif

    assign bus.cmd_ready    = (state_q == S_IDLE);
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.done         = done_q;
    assign bus.data_we      = we_q;
    assign bus.data_address = $signed({20'd0, addr_q});
    assign bus.data_din     = $signed(din_q);

endmodule

// File: tb/tb_vram_rect_fill.sv
// Directed testbench for vram_rect_fill: reset values, raster fill order,
// clipping, empty commands, full-frame throughput, mid-fill reset and,
// when VRAM_RECT_FILL_VSYNC_WAIT_EN is defined, the vsync-gated start.
module tb_vram_rect_fill;

    logic clk = 1'b0;
    logic reset;
    int   cycle = 0;
    int   checks = 0;
    int   failures = 0;

    vram_rect_fill_if bus ();

    vram_rect_fill #(.C_FB_W(64), .C_FB_H(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // 10 ns system clock.
    always #5 clk = ~clk;

    // Cycle index: value seen during a cycle is the number of edges so far.
    always @(posedge clk) cycle <= cycle + 1;

    logic [11:0] wrAddr[$];
    logic [7:0]  wrData[$];
    int          wrCycle[$];
    int          doneCycle[$];
    int          doneBusy[$];
    int          busyCount;

    // Log every write, done pulse and busy cycle mid-cycle, away from the edge.
    always @(negedge clk) begin
        if (bus.busy === 1'b1) busyCount++;
        if (bus.data_we === 1'b1) begin
            wrAddr.push_back(bus.data_address[11:0]);
            wrData.push_back(bus.data_din);
            wrCycle.push_back(cycle);
        end
        if (bus.done === 1'b1) begin
            doneCycle.push_back(cycle);
            doneBusy.push_back(busyCount);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clearLogs();
        wrAddr.delete();
        wrData.delete();
        wrCycle.delete();
        doneCycle.delete();
        doneBusy.delete();
        busyCount = 0;
    endtask

    // Present a command and return the cycle in which it is accepted.
    // cmd_valid is left high; the caller decides when to drop it.
    task automatic applyStimulus(input logic [5:0] x, input logic [5:0] y,
                                 input logic [6:0] w, input logic [6:0] h,
                                 input logic [7:0] c, output int acc);
        int budget;
        clearLogs();
        bus.cmd_x     = x;
        bus.cmd_y     = y;
        bus.cmd_w     = w;
        bus.cmd_h     = h;
        bus.cmd_color = c;
        bus.cmd_valid = 1'b1;
        budget = 100;
        while (bus.cmd_ready !== 1'b1 && budget > 0) begin
            step();
            budget--;
        end
        acc = cycle;
        step();
    endtask

    // Wait for n done pulses; ok is cleared when the cycle budget runs out.
    task automatic waitDone(input int n, input int budget, output bit ok);
        ok = 1'b1;
        while (doneCycle.size() < n) begin
            if (budget == 0) begin
                ok = 1'b0;
                break;
            end
            step();
            budget--;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        checks++; if (bus.cmd_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_cmd_ready: got %b expected 1", bus.cmd_ready); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b expected 0", bus.done); end
        checks++; if (bus.data_we !== 1'b0) begin failures++; $display("[TB] FAIL reset_we: got %b expected 0", bus.data_we); end
        checks++; if (bus.data_address !== 32'sd0) begin failures++; $display("[TB] FAIL reset_addr: got %0h expected 0", bus.data_address); end
        checks++; if (bus.data_din !== 8'sd0) begin failures++; $display("[TB] FAIL reset_din: got %0h expected 0", bus.data_din); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_basic();
        int acc;
        bit ok;
        logic [11:0] expAddr [8];
        expAddr = '{12'h0C2, 12'h0C3, 12'h0C4, 12'h0C5, 12'h102, 12'h103, 12'h104, 12'h105};
        applyStimulus(6'd2, 6'd3, 7'd4, 7'd2, 8'hE3, acc);
        bus.cmd_valid = 1'b0;
        waitDone(1, 100, ok);
        checks++; if (!ok) begin failures++; $display("[TB] FAIL basic_timeout: got no done expected done"); end
        checks++; if (wrAddr.size() != 8) begin failures++; $display("[TB] FAIL basic_count: got %0d expected 8", wrAddr.size()); end
        for (int i = 0; i < 8 && i < wrAddr.size(); i++) begin
            checks++; if (wrAddr[i] !== expAddr[i]) begin failures++; $display("[TB] FAIL basic_addr[%0d]: got %0h expected %0h", i, wrAddr[i], expAddr[i]); end
            checks++; if (wrData[i] !== 8'hE3) begin failures++; $display("[TB] FAIL basic_data[%0d]: got %0h expected e3", i, wrData[i]); end
            checks++; if (wrCycle[i] != acc + 1 + i) begin failures++; $display("[TB] FAIL basic_cycle[%0d]: got %0d expected %0d", i, wrCycle[i], acc + 1 + i); end
        end
        if (ok) begin
            checks++; if (doneCycle[0] != acc + 9) begin failures++; $display("[TB] FAIL basic_done_cycle: got %0d expected %0d", doneCycle[0], acc + 9); end
            checks++; if (bus.cmd_ready !== 1'b1 || cycle != acc + 10) begin failures++; $display("[TB] FAIL basic_ready: got %b at %0d expected 1 at %0d", bus.cmd_ready, cycle, acc + 10); end
        end
    endtask

    task automatic test_clip();
        int acc;
        bit ok;
        applyStimulus(6'd62, 6'd63, 7'd10, 7'd10, 8'h1C, acc);
        bus.cmd_valid = 1'b0;
        waitDone(1, 100, ok);
        checks++; if (!ok) begin failures++; $display("[TB] FAIL clip_timeout: got no done expected done"); end
        checks++; if (wrAddr.size() != 2) begin failures++; $display("[TB] FAIL clip_count: got %0d expected 2", wrAddr.size()); end
        if (wrAddr.size() >= 2) begin
            checks++; if (wrAddr[0] !== 12'hFFE) begin failures++; $display("[TB] FAIL clip_addr0: got %0h expected ffe", wrAddr[0]); end
            checks++; if (wrAddr[1] !== 12'hFFF) begin failures++; $display("[TB] FAIL clip_addr1: got %0h expected fff", wrAddr[1]); end
        end
        if (ok) begin
            checks++; if (doneCycle[0] != acc + 3) begin failures++; $display("[TB] FAIL clip_done_cycle: got %0d expected %0d", doneCycle[0], acc + 3); end
        end
    endtask

    task automatic test_zero_size();
        int acc;
        bit ok;
        applyStimulus(6'd7, 6'd9, 7'd0, 7'd5, 8'hFF, acc);
        bus.cmd_valid = 1'b0;
        waitDone(1, 20, ok);
        checks++; if (!ok) begin failures++; $display("[TB] FAIL zero_timeout: got no done expected done"); end
        checks++; if (wrAddr.size() != 0) begin failures++; $display("[TB] FAIL zero_writes: got %0d expected 0", wrAddr.size()); end
        if (ok) begin
            checks++; if (doneCycle[0] != acc + 1) begin failures++; $display("[TB] FAIL zero_done_cycle: got %0d expected %0d", doneCycle[0], acc + 1); end
            checks++; if (bus.cmd_ready !== 1'b1) begin failures++; $display("[TB] FAIL zero_ready: got %b expected 1", bus.cmd_ready); end
        end
    endtask

    task automatic test_back_to_back();
        int acc;
        bit ok;
        int seqBad;
        applyStimulus(6'd0, 6'd0, 7'd64, 7'd64, 8'h5A, acc);
        // Keep cmd_valid high with a 1x1 command at (5,5) for the whole fill.
        bus.cmd_x = 6'd5; bus.cmd_y = 6'd5; bus.cmd_w = 7'd1; bus.cmd_h = 7'd1; bus.cmd_color = 8'h11;
        waitDone(1, 5000, ok);
        checks++; if (!ok) begin failures++; $display("[TB] FAIL full_timeout: got no done expected done"); end
        checks++; if (wrAddr.size() != 4096) begin failures++; $display("[TB] FAIL full_count: got %0d expected 4096", wrAddr.size()); end
        seqBad = 0;
        for (int i = 0; i < 4096 && i < wrAddr.size(); i++) begin
            if (wrAddr[i] !== 12'(i) || wrCycle[i] != acc + 1 + i) seqBad++;
        end
        checks++; if (seqBad != 0) begin failures++; $display("[TB] FAIL full_sequence: got %0d bad writes expected 0", seqBad); end
        if (ok) begin
            checks++; if (doneBusy[0] != 4097) begin failures++; $display("[TB] FAIL full_busy_cycles: got %0d expected 4097", doneBusy[0]); end
            checks++; if (doneCycle[0] != acc + 4097) begin failures++; $display("[TB] FAIL full_done_cycle: got %0d expected %0d", doneCycle[0], acc + 4097); end
        end
        step();
        bus.cmd_valid = 1'b0;
        waitDone(2, 20, ok);
        checks++; if (!ok || wrAddr.size() != 4097) begin failures++; $display("[TB] FAIL held_cmd_count: got %0d writes expected 4097", wrAddr.size()); end
        if (ok && wrAddr.size() == 4097) begin
            checks++; if (wrAddr[4096] !== 12'h145) begin failures++; $display("[TB] FAIL held_cmd_addr: got %0h expected 145", wrAddr[4096]); end
            checks++; if (wrCycle[4096] != doneCycle[0] + 2) begin failures++; $display("[TB] FAIL held_cmd_cycle: got %0d expected %0d", wrCycle[4096], doneCycle[0] + 2); end
        end
    endtask

    task automatic test_reset_mid_fill();
        int acc;
        applyStimulus(6'd0, 6'd0, 7'd64, 7'd64, 8'h33, acc);
        bus.cmd_valid = 1'b0;
        while (cycle < acc + 10) step();
        // Reset lands on the 10th write, with a competing command presented.
        reset = 1'b1;
        bus.cmd_x = 6'd1; bus.cmd_y = 6'd1; bus.cmd_w = 7'd1; bus.cmd_h = 7'd1; bus.cmd_color = 8'h99;
        bus.cmd_valid = 1'b1;
        step();
        checks++; if (bus.data_we !== 1'b0) begin failures++; $display("[TB] FAIL midreset_we: got %b expected 0", bus.data_we); end
        step();
        reset = 1'b0;
        bus.cmd_valid = 1'b0;
        repeat (10) step();
        checks++; if (wrAddr.size() != 10) begin failures++; $display("[TB] FAIL midreset_writes: got %0d expected 10", wrAddr.size()); end
        checks++; if (doneCycle.size() != 0) begin failures++; $display("[TB] FAIL midreset_done: got %0d pulses expected 0", doneCycle.size()); end
        checks++; if (bus.cmd_ready !== 1'b1) begin failures++; $display("[TB] FAIL midreset_ready: got %b expected 1", bus.cmd_ready); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL midreset_busy: got %b expected 0", bus.busy); end
    endtask

`ifdef VRAM_RECT_FILL_VSYNC_WAIT_EN
    task automatic test_vsync_wait();
        int acc;
        int v;
        bit ok;
        applyStimulus(6'd10, 6'd20, 7'd2, 7'd1, 8'h77, acc);
        bus.cmd_valid = 1'b0;
        repeat (8) step();
        checks++; if (wrAddr.size() != 0) begin failures++; $display("[TB] FAIL vs_early_write: got %0d writes expected 0", wrAddr.size()); end
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("[TB] FAIL vs_busy: got %b expected 1", bus.busy); end
        v = cycle;
        bus.vsync = 1'b0;
        waitDone(1, 50, ok);
        bus.vsync = 1'b1;
        checks++; if (!ok || wrAddr.size() != 2) begin failures++; $display("[TB] FAIL vs_count: got %0d expected 2", wrAddr.size()); end
        if (ok && wrAddr.size() == 2) begin
            checks++; if (wrCycle[0] != v + 3) begin failures++; $display("[TB] FAIL vs_first_cycle: got %0d expected %0d", wrCycle[0], v + 3); end
            checks++; if (wrAddr[0] !== 12'h50A || wrAddr[1] !== 12'h50B) begin failures++; $display("[TB] FAIL vs_addr: got %0h,%0h expected 50a,50b", wrAddr[0], wrAddr[1]); end
            checks++; if (doneCycle[0] != v + 5) begin failures++; $display("[TB] FAIL vs_done_cycle: got %0d expected %0d", doneCycle[0], v + 5); end
        end
    endtask
`endif

    // Run every scenario in order, then report.
    initial begin
        reset         = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_x     = 6'd0;
        bus.cmd_y     = 6'd0;
        bus.cmd_w     = 7'd0;
        bus.cmd_h     = 7'd0;
        bus.cmd_color = 8'd0;
        bus.vsync     = 1'b1;
        clearLogs();
        test_reset();
`ifdef VRAM_RECT_FILL_VSYNC_WAIT_EN
        test_vsync_wait();
`else
        test_basic();
        test_clip();
        test_zero_size();
        test_back_to_back();
        test_reset_mid_fill();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
